// File: rtl/wb_reg_peripheral_pkg.sv
// Shared types and helpers for the Wishbone register peripheral:
// FSM state encoding, default tag width and a ceil-log2 helper.
package wb_reg_peripheral_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } wb_state_t;

   localparam int unsigned DEF_TAG_WIDTH = 1;
   localparam int unsigned CNT_WIDTH     = 4;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned v;
      res = 0;
      v   = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_reg_peripheral_if.sv
// Wishbone B4 classic bus bundle; master drives requests, slave drives terminations.
interface wb_reg_peripheral_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8,
   parameter int unsigned TGDI_WIDTH = 1,
   parameter int unsigned TGDO_WIDTH = 1,
   parameter int unsigned TGA_WIDTH  = 1,
   parameter int unsigned TGC_WIDTH  = 1
);
   logic [ADDR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0] dat_wr;
   logic [DATA_WIDTH-1:0] dat_rd;
   logic                  ack;
   logic                  err;
   logic                  rty;
   logic                  cyc;
   logic                  stb;
   logic                  lock;
   logic                  we;
   logic [SEL_WIDTH-1:0]  sel;
   logic [TGDI_WIDTH-1:0] tgd_wr;
   logic [TGDO_WIDTH-1:0] tgd_rd;
   logic [TGA_WIDTH-1:0]  tga;
   logic [TGC_WIDTH-1:0]  tgc;

   modport master (
      output adr, dat_wr, cyc, stb, lock, we, sel, tgd_wr, tga, tgc,
      input  dat_rd, ack, err, rty, tgd_rd
   );

   modport slave (
      input  adr, dat_wr, cyc, stb, lock, we, sel, tgd_wr, tga, tgc,
      output dat_rd, ack, err, rty, tgd_rd
   );
endinterface

// File: rtl/wb_reg_peripheral_reg_bank.sv
// Register storage: byte-enable write port, combinational read mux,
// RO_MASK selects between local storage and fabric-sampled regs_i.
module wb_reg_bank #(
   parameter int unsigned     DATA_WIDTH = 32,
   parameter int unsigned     SEL_WIDTH  = DATA_WIDTH / 8,
   parameter int unsigned     NUM_REGS   = 8,
   parameter int unsigned     IDX_WIDTH  = 3,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [IDX_WIDTH-1:0]           wr_idx,
   input  logic [SEL_WIDTH-1:0]           wr_sel,
   input  logic [DATA_WIDTH-1:0]          wr_dat,
   input  logic [IDX_WIDTH-1:0]           rd_idx,
   output logic [DATA_WIDTH-1:0]          rd_dat,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_i,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   logic [DATA_WIDTH-1:0] store [NUM_REGS];
   logic                  unused_regs_i;

   // RO lanes of regs_i are the only ones consumed; RW lanes are ignored.
   assign unused_regs_i = ^regs_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            store[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_en && !RO_MASK[i] && (wr_idx == IDX_WIDTH'(i))) begin
               for (int unsigned b = 0; b < SEL_WIDTH; b++) begin
                  if (wr_sel[b]) begin
                     store[i][b*8 +: 8] <= wr_dat[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   always_comb begin
      rd_dat = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_WIDTH'(i)) begin
            rd_dat = RO_MASK[i] ? regs_i[i*DATA_WIDTH +: DATA_WIDTH] : store[i];
         end
      end
   end

   always_comb begin
      regs_o = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (!RO_MASK[i]) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = store[i];
         end
      end
   end

endmodule

// File: rtl/wb_reg_peripheral.sv
// Wishbone B4 classic register slave: address decode, request latch, wait-state
// FSM and registered ack/err/data/tag response around a wb_reg_bank.
module wb_reg_peripheral
   import wb_reg_peripheral_pkg::*;
#(
   parameter int unsigned         ADDR_WIDTH  = 32,
   parameter int unsigned         DATA_WIDTH  = 32,
   parameter int unsigned         SEL_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned         TGDI_WIDTH  = DEF_TAG_WIDTH,
   parameter int unsigned         TGDO_WIDTH  = DEF_TAG_WIDTH,
   parameter int unsigned         TGA_WIDTH   = DEF_TAG_WIDTH,
   parameter int unsigned         TGC_WIDTH   = DEF_TAG_WIDTH,
   parameter int unsigned         NUM_REGS    = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int unsigned         WAIT_STATES = 1,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   wb_reg_peripheral_if.slave             wb,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_i
);

   localparam int unsigned             IDX_WIDTH = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0]   SEL_BYTES = ADDR_WIDTH'(SEL_WIDTH);
   localparam logic [ADDR_WIDTH-1:0]   REG_COUNT = ADDR_WIDTH'(NUM_REGS);
   localparam logic [CNT_WIDTH-1:0]    CNT_INIT  =
      (WAIT_STATES == 0) ? '0 : CNT_WIDTH'(WAIT_STATES - 1);

   wb_state_t              state, state_nxt;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [IDX_WIDTH-1:0]   idx_q;
   logic                   we_q;
   logic                   err_q;
   logic [SEL_WIDTH-1:0]   sel_q;
   logic [DATA_WIDTH-1:0]  dat_q;
   logic [TGC_WIDTH-1:0]   tgc_q;

   logic [ADDR_WIDTH-1:0]  off;
   logic [ADDR_WIDTH-1:0]  word;
   logic                   req_err;
   logic                   accept;
   logic                   resp;
   logic                   commit;
   logic [DATA_WIDTH-1:0]  rd_dat;
   logic [TGDO_WIDTH-1:0]  tgd_echo;

   logic                   unused_lock;
   logic [TGDI_WIDTH-1:0]  unused_tgd;
   logic [TGA_WIDTH-1:0]   unused_tga;

   assign unused_lock = wb.lock;
   assign unused_tgd  = wb.tgd_wr;
   assign unused_tga  = wb.tga;
   assign wb.rty      = 1'b0;

   // Below-base addresses wrap to large offsets, but are flagged explicitly anyway.
   always_comb begin
      off     = wb.adr - BASE_ADDR;
      word    = off / SEL_BYTES;
      req_err = (wb.adr < BASE_ADDR) || (word >= REG_COUNT) || ((off % SEL_BYTES) != '0);
      if (!req_err && wb.we && RO_MASK[word[IDX_WIDTH-1:0]]) begin
         req_err = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (wb.cyc && wb.stb) begin
               state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!wb.cyc) begin
               state_nxt = ST_IDLE;
            end else if (cnt == '0) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      accept = (state == ST_IDLE) && wb.cyc && wb.stb;
      resp   = (state == ST_RESP);
      commit = resp && we_q && !err_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt   <= '0;
         idx_q <= '0;
         we_q  <= 1'b0;
         err_q <= 1'b0;
         sel_q <= '0;
         dat_q <= '0;
         tgc_q <= '0;
      end else if (accept) begin
         cnt   <= CNT_INIT;
         idx_q <= word[IDX_WIDTH-1:0];
         we_q  <= wb.we;
         err_q <= req_err;
         sel_q <= wb.sel;
         dat_q <= wb.dat_wr;
         tgc_q <= wb.tgc;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_comb begin
      tgd_echo = '0;
      for (int unsigned i = 0; i < TGDO_WIDTH; i++) begin
         if (i < TGC_WIDTH) begin
            tgd_echo[i] = tgc_q[i];
         end
      end
   end

   // Response is registered on the RESP edge, so it is seen the cycle after RESP.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb.ack    <= 1'b0;
         wb.err    <= 1'b0;
         wb.dat_rd <= '0;
         wb.tgd_rd <= '0;
      end else begin
         wb.ack    <= resp && !err_q;
         wb.err    <= resp && err_q;
         wb.dat_rd <= (resp && !err_q && !we_q) ? rd_dat : '0;
         wb.tgd_rd <= resp ? tgd_echo : '0;
      end
   end

   wb_reg_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (SEL_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_WIDTH  (IDX_WIDTH),
      .RO_MASK    (RO_MASK)
   ) u_bank (
      .clk    (clk_i),
      .rst    (rst_i),
      .wr_en  (commit),
      .wr_idx (idx_q),
      .wr_sel (sel_q),
      .wr_dat (dat_q),
      .rd_idx (idx_q),
      .rd_dat (rd_dat),
      .regs_i (regs_i),
      .regs_o (regs_o)
   );

endmodule

// File: tb/tb_wb_reg_peripheral.sv
// Self-checking bench: three peripheral instances (1, 3 and 0 wait states) on a shared
// stimulus bus, checked against an array-based model of the register map.
module tb_wb_reg_peripheral;

   localparam int unsigned NR   = 8;
   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 32;
   localparam logic [31:0] BASE = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0]        adr;
   logic [31:0]        dat;
   logic               we;
   logic               cyc;
   logic               stb;
   logic               tgc;
   logic [3:0]         sel;
   int                 tgt;
   logic [NR*DW-1:0]   regs_i;
   logic [NR*DW-1:0]   regs_o_v [3];

   logic               ack_v [3];
   logic               err_v [3];
   logic               rty_v [3];
   logic [31:0]        dat_v [3];
   logic               tgd_v [3];
   logic               ack_o, err_o, rty_o, tgd_o;
   logic [31:0]        dat_o;

   int unsigned        wait_of [3] = '{1, 3, 0};
   logic [7:0]         ro_of   [3] = '{8'h80, 8'h00, 8'h80};
   logic [31:0]        mdl [3][NR];

   int                 checks = 0;
   int                 errors = 0;

   wb_reg_peripheral_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus [3] ();

   for (genvar k = 0; k < 3; k++) begin : g_bus
      assign bus[k].adr    = adr;
      assign bus[k].dat_wr = dat;
      assign bus[k].we     = we;
      assign bus[k].sel    = sel;
      assign bus[k].tgc    = tgc;
      assign bus[k].cyc    = cyc && (tgt == k);
      assign bus[k].stb    = stb && (tgt == k);
      assign bus[k].lock   = 1'b0;
      assign bus[k].tga    = 1'b0;
      assign bus[k].tgd_wr = 1'b0;
      assign ack_v[k]      = bus[k].ack;
      assign err_v[k]      = bus[k].err;
      assign rty_v[k]      = bus[k].rty;
      assign dat_v[k]      = bus[k].dat_rd;
      assign tgd_v[k]      = bus[k].tgd_rd;
   end

   always_comb begin
      ack_o = ack_v[tgt];
      err_o = err_v[tgt];
      rty_o = rty_v[tgt];
      dat_o = dat_v[tgt];
      tgd_o = tgd_v[tgt];
   end

   wb_reg_peripheral #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE),
      .WAIT_STATES(1), .RO_MASK(8'h80)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .wb(bus[0]), .regs_o(regs_o_v[0]), .regs_i(regs_i)
   );

   wb_reg_peripheral #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE),
      .WAIT_STATES(3), .RO_MASK(8'h00)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .wb(bus[1]), .regs_o(regs_o_v[1]), .regs_i(regs_i)
   );

   wb_reg_peripheral #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE),
      .WAIT_STATES(0), .RO_MASK(8'h80)
   ) dut_c (
      .clk_i(clk), .rst_i(rst), .wb(bus[2]), .regs_o(regs_o_v[2]), .regs_i(regs_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int t = 0; t < 3; t++)
         for (int i = 0; i < NR; i++)
            mdl[t][i] = '0;
   endtask

   task automatic check_regs(input int t, input string tag);
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (!ro_of[t][i])
            chk($sformatf("%s reg%0d", tag, i), 64'(regs_o_v[t][i*32 +: 32]), 64'(mdl[t][i]));
      end
   endtask

   // One complete bus transfer, held until a termination or a 40-cycle bound.
   task automatic xfer(input int t, input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic tg, input string tag);
      int unsigned lat;
      logic        exp_err;
      int          idx;
      logic [31:0] exp_dat;
      logic        got_ack, got_err, got_tgd;
      logic [31:0] got_dat;
      exp_err = 1'b0;
      idx     = 0;
      if (a < BASE || ((a - BASE) % 4) != 0 || ((a - BASE) / 4) >= NR) begin
         exp_err = 1'b1;
      end else begin
         idx = int'((a - BASE) / 4);
         if (w && ro_of[t][idx]) exp_err = 1'b1;
      end
      exp_dat = '0;
      if (!exp_err && !w) exp_dat = ro_of[t][idx] ? regs_i[idx*32 +: 32] : mdl[t][idx];

      tgt = t; adr = a; we = w; sel = s; dat = d; tgc = tg; cyc = 1'b1; stb = 1'b1;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (ack_o || err_o) break;
      end
      got_ack = ack_o; got_err = err_o; got_dat = dat_o; got_tgd = tgd_o;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;

      chk({tag, " latency"}, 64'(lat), 64'(wait_of[t] + 2));
      chk({tag, " ack"}, 64'(got_ack), 64'(!exp_err));
      chk({tag, " err"}, 64'(got_err), 64'(exp_err));
      if (exp_err || !w) chk({tag, " dat"}, 64'(got_dat), 64'(exp_dat));
      chk({tag, " tgd"}, 64'(got_tgd), 64'(tg));
      if (!exp_err && w) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) mdl[t][idx][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic        seen;
      logic [31:0] ra;
      logic        rw;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
      tgc = 1'b0; tgt = 0; regs_i = '0;
      clear_model();
      repeat (3) @(negedge clk);
      chk("reset ack", 64'(ack_o), 64'(0));
      chk("reset err", 64'(err_o), 64'(0));
      chk("reset rty", 64'(rty_o), 64'(0));
      chk("reset dat", 64'(dat_o), 64'(0));
      chk("reset tgd", 64'(tgd_o), 64'(0));
      rst = 1'b0;
      for (int t = 0; t < 3; t++) check_regs(t, "reset");

      // Full-word write, regs_o follow-up, readback.
      xfer(0, BASE + 8, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, "t1 wr");
      check_regs(0, "t1");
      xfer(0, BASE + 8, 1'b0, 4'hF, 32'h0, 1'b1, "t1 rd");

      // Byte-lane merge.
      xfer(0, BASE + 0, 1'b1, 4'hF, 32'h1122_3344, 1'b0, "t2 wr0");
      xfer(0, BASE + 0, 1'b1, 4'b0101, 32'hAABB_CCDD, 1'b1, "t2 wr1");
      xfer(0, BASE + 0, 1'b0, 4'h0, 32'h0, 1'b0, "t2 rd");
      chk("t2 merged word", 64'(mdl[0][0]), 64'(32'h11BB_33DD));
      xfer(0, BASE + 4, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, "t2 sel0");

      // Error responses and RO read.
      xfer(0, BASE + 32, 1'b0, 4'hF, 32'h0, 1'b0, "t3 idx8");
      xfer(0, BASE + 2, 1'b1, 4'hF, 32'h5555_5555, 1'b1, "t3 misalign");
      xfer(0, BASE - 4, 1'b0, 4'hF, 32'h0, 1'b0, "t3 below");
      xfer(0, BASE + 28, 1'b1, 4'hF, 32'h7777_7777, 1'b0, "t3 ro wr");
      check_regs(0, "t3");
      regs_i[7*32 +: 32] = 32'h0000_5A5A;
      xfer(0, BASE + 28, 1'b0, 4'hF, 32'h0, 1'b1, "t3 ro rd");

      // Randomized traffic on the 1-wait-state instance.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NR; i++) regs_i[i*32 +: 32] = $urandom;
         ra = BASE + 32'($urandom_range(0, 9)) * 4;
         if ($urandom_range(0, 7) == 0) ra = ra + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) ra = BASE - 32'($urandom_range(1, 16));
         rw = 1'($urandom_range(0, 1));
         xfer(0, ra, rw, 4'($urandom), $urandom, 1'($urandom), $sformatf("rnd%0d", n));
         if (rw) check_regs(0, $sformatf("rnd%0d", n));
      end

      // Abort during wait states.
      xfer(1, BASE + 4, 1'b1, 4'hF, 32'hCAFE_0001, 1'b0, "t4 setup");
      tgt = 1; adr = BASE + 4; we = 1'b1; sel = 4'hF; dat = 32'h0BAD_0BAD; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ack_o || err_o) seen = 1'b1;
      end
      chk("t4 no termination", 64'(seen), 64'(0));
      check_regs(1, "t4");
      xfer(1, BASE + 4, 1'b0, 4'hF, 32'h0, 1'b1, "t4 rd");

      // Zero wait states, back-to-back with tag echo.
      xfer(2, BASE + 12, 1'b1, 4'hF, 32'h1234_5678, 1'b0, "t5 wr");
      xfer(2, BASE + 12, 1'b0, 4'hF, 32'h0, 1'b1, "t5 rd tag1");
      xfer(2, BASE + 12, 1'b0, 4'hF, 32'h0, 1'b0, "t5 rd tag0");

      // Reset in the middle of a write.
      tgt = 0; adr = BASE + 16; we = 1'b1; sel = 4'hF; dat = 32'hFFFF_FFFF; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (ack_o || err_o) seen = 1'b1;
      end
      chk("t6 no termination", 64'(seen), 64'(0));
      chk("t6 dat", 64'(dat_o), 64'(0));
      chk("t6 tgd", 64'(tgd_o), 64'(0));
      cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
      clear_model();
      for (int t = 0; t < 3; t++) check_regs(t, "t6");
      xfer(0, BASE + 16, 1'b0, 4'hF, 32'h0, 1'b0, "t6 rd");
      xfer(0, BASE + 8, 1'b0, 4'hF, 32'h0, 1'b0, "t6 rd2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
